// File: rtl/mult_pkg.sv
// Shared types and width constants for the multiplier / accumulator path.
// Holds the accumulator state enum, default widths and the ACC_W sizing rule.
package mult_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } acc_state_t;

   localparam int PROD_W      = 8;
   localparam int N_TERMS_DEF = 4;

   // Smallest accumulator that cannot overflow for n_terms products.
   function automatic int min_acc_w(input int data_w, input int n_terms);
      return data_w + $clog2(n_terms);
   endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums groups of N_TERMS unsigned products and holds each sum on a valid/ready port.
// Ports: clk, n_rst, sclr | in_valid/in_data/in_ready | out_valid/out_data/out_ready | term_cnt
module product_accumulator
   import mult_pkg::*;
#(
   parameter int DATA_W  = PROD_W,
   parameter int N_TERMS = N_TERMS_DEF,
   parameter int ACC_W   = 10
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       sclr,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [ACC_W-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(N_TERMS):0]   term_cnt
);

   localparam int CNT_W = $clog2(N_TERMS) + 1;

   if (N_TERMS < 2 || N_TERMS > 16) begin : g_bad_terms
      $error("product_accumulator: N_TERMS must be 2..16");
   end

   if (ACC_W < min_acc_w(DATA_W, N_TERMS)) begin : g_bad_acc_w
      $error("product_accumulator: ACC_W too small for N_TERMS products");
   end

   acc_state_t       state;
   acc_state_t       state_n;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum;
   logic             accept;
   logic             last;

   assign in_ready = (state == ACCUM);
   assign accept   = in_valid && in_ready;
   assign last     = (term_cnt == CNT_W'(N_TERMS - 1));
   assign sum      = acc + ACC_W'(in_data);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= ACCUM;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      if (sclr) begin
         state_n = ACCUM;
      end else begin
         unique case (state)
            ACCUM: if (accept && last) state_n = DONE;
            DONE:  if (out_ready)      state_n = ACCUM;
            default: state_n = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         acc       <= '0;
         term_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (sclr) begin
         acc       <= '0;
         term_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (accept) begin
         if (last) begin
            // Final term goes straight to the output; the group restarts empty.
            out_data  <= sum;
            out_valid <= 1'b1;
            acc       <= '0;
            term_cnt  <= '0;
         end else begin
            acc      <= sum;
            term_cnt <= term_cnt + CNT_W'(1);
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage that sits directly downstream of the 4-bit shift-add multiplier. It consumes the multiplier's registered 8-bit products one per handshake and sums a fixed group of `N_TERMS` products, which forms a dot product of `N_TERMS` operand pairs. It presents the group sum on a valid/ready output port and holds it until the consumer takes it.

## Interface
- `DATA_W`, default 8: width of incoming product; matches multiplier `out`.
- `N_TERMS`, default 4: products summed per group; legal range 2..16.
- `ACC_W`, default 10: accumulator/result width; must be ≥ `DATA_W + $clog2(N_TERMS)`. Elaboration error otherwise.
- `clk`, input, 1: single clock, rising edge.
- `n_rst`, input, 1: asynchronous, active-low reset.
- `sclr`, input, 1: synchronous clear; aborts the current group.
- `in_valid`, input, 1: `in_data` carries a valid product.
- `in_data`, input, `DATA_W`: unsigned product from the multiplier stage.
- `in_ready`, output, 1: stage accepts `in_data` this cycle.
- `out_valid`, output, 1: `out_data` holds a completed group sum.
- `out_data`, output, `ACC_W`: unsigned group sum.
- `out_ready`, input, 1: consumer takes `out_data` this cycle.
- `term_cnt`, output, `$clog2(N_TERMS)+1`: products accepted in the current group.

## Operation
- Two states:
  - `ACCUM`: `in_ready`=1, `out_valid`=0.
  - `DONE`: `in_ready`=0, `out_valid`=1.
- Input handshake: a product is accepted when `in_valid && in_ready`. `in_data` is sampled only on acceptance.
- In `ACCUM`, each acceptance does `acc <= acc + in_data` (zero-extended to `ACC_W`) and `term_cnt <= term_cnt + 1`.
- Group completion: on the acceptance that makes `term_cnt` reach `N_TERMS`:
  - `out_data <= acc + in_data`
  - transition to `DONE`
  - `acc` and `term_cnt` cleared.
- In `DONE`: `out_data` and `out_valid` stay stable until `out_ready`=1. That cycle returns the stage to `ACCUM`.
- No input acceptance in the drain cycle. `in_ready` rises the cycle after the drain.
- Arithmetic is unsigned. With legal `ACC_W` there is no overflow. If the width rule were violated the sum would wrap modulo 2^`ACC_W`, but the parameter check forbids this.
- `sclr`=1 at a clock edge, in any state:
  - `acc`, `term_cnt`, `out_valid` and `out_data` are cleared
  - state goes to `ACCUM`
  - `sclr` has priority over a simultaneous input or output handshake, and the data in that handshake is discarded.
- `in_valid` without `in_ready`: the product is not consumed. Upstream must hold it.
- `term_cnt` never exceeds `N_TERMS - 1` in `ACCUM` and reads 0 in `DONE`.

## Timing
- Reset (`n_rst`=0, asynchronous): state `ACCUM`, `acc`=0, `term_cnt`=0, `out_valid`=0, `out_data`=0, `in_ready`=1 (combinational from state). Reset mid-group discards the partial sum.
- Latency: last product accepted at edge k → `out_valid`=1 with the sum visible after edge k.
- Throughput: without backpressure, one group per `N_TERMS`+1 cycles (`N_TERMS` accept cycles plus 1 drain cycle).
- All outputs are registered except `in_ready`, which is a decode of the state register.
- `out_valid` never drops without `out_ready` or `sclr`.
- The multiplier's 1-cycle product latency is absorbed upstream. The wrapper drives `in_valid` one cycle after the operands are applied.

## Structure
- Shared package `mult_pkg`:
  - state enum `acc_state_t` {`ACCUM`, `DONE`}
  - default width constants `PROD_W`=8, `N_TERMS_DEF`=4
  - function computing the minimum `ACC_W`.
- Single module; no sub-module. Counter, accumulator and FSM are small enough to live inline.

## Test plan
- Group sum: reset; 4 products of 225 back-to-back, `out_ready`=1 → `out_valid`=1 one cycle after the 4th accept, `out_data`=900 (0x384); `in_ready`=1 again 1 cycle later.
- Backpressure: products 1, 2, 3, 4; `out_ready`=0 for 3 cycles → `out_data`=10 held stable, `in_ready`=0 throughout; drain on `out_ready`=1; next group of 5, 5, 5, 5 gives 20.
- Input gaps: products 7, idle 2 cycles, 8, idle, 9, 10 with sparse `in_valid` → `term_cnt` steps 1, 2, 3; `out_data`=34.
- `sclr` mid-group: after 50 and 60, assert `sclr` together with `in_valid` of 70 → `term_cnt`=0, 70 discarded; next 4×1 gives `out_data`=4.
- Async reset: drop `n_rst` mid-cycle while in `DONE` holding 900 → `out_valid`=0, `out_data`=0, `in_ready`=1 immediately, with no clock edge required.
- Parameter sweep: `N_TERMS`=16, `ACC_W`=12, 16×255 → `out_data`=4080 with no wrap.
